// File: rtl/mux_16to1_pkg.sv
// Shared constants and helpers for the 16:1 mux tree.
// Tree nodes are numbered leaves first, so each level's base index is computable.
package mux_16to1_pkg;
  localparam int N_IN    = 16;
  localparam int SEL_W   = 4;
  localparam int N_NODES = 2 * N_IN - 1;

  typedef logic [SEL_W-1:0] sel_t;

  // First node index of tree level lvl (0 = the 16 inputs, SEL_W = root).
  function automatic int lvl_base(input int lvl);
    return 2 * N_IN - ((2 * N_IN) >> lvl);
  endfunction
endpackage

// File: rtl/mux_2to1.sv
// Single 2:1 selector cell used to build the binary mux tree.
module mux_2to1 #(
  parameter int DATA_W = 1
) (
  input  logic [DATA_W-1:0] d0,
  input  logic [DATA_W-1:0] d1,
  input  logic              sel,
  output logic [DATA_W-1:0] y
);
  assign y = sel ? d1 : d0;
endmodule

// File: rtl/mux_16to1.sv
// 16:1 multiplexer built as a 4-level tree of 2:1 cells, with a combinational
// output plus a registered copy of the selected data and select.
module mux_16to1
  import mux_16to1_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_IN*DATA_W-1:0] in,
  input  sel_t                   sel,
  output logic [DATA_W-1:0]      out,
  output logic [DATA_W-1:0]      out_q,
  output sel_t                   sel_q
);
  logic [DATA_W-1:0] node [N_NODES];
  logic [DATA_W-1:0] out_p1;
  sel_t              sel_p1;

  for (genvar k = 0; k < N_IN; k++) begin : g_leaf
    assign node[k] = in[k*DATA_W +: DATA_W];
  end

  // sel[lvl] steers level lvl; sel[0] picks between adjacent inputs at the leaves.
  for (genvar lvl = 0; lvl < SEL_W; lvl++) begin : g_lvl
    for (genvar j = 0; j < (N_IN >> (lvl + 1)); j++) begin : g_cell
      localparam int SRC = lvl_base(lvl) + 2 * j;
      localparam int DST = lvl_base(lvl + 1) + j;
      mux_2to1 #(.DATA_W(DATA_W)) u_mux (
        .d0  (node[SRC]),
        .d1  (node[SRC+1]),
        .sel (sel[lvl]),
        .y   (node[DST])
      );
    end
  end

  assign out = node[N_NODES-1];

  // Stage p0 -> p1: capture selected data together with its select.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_p1 <= '0;
      sel_p1 <= '0;
    end else begin
      out_p1 <= out;
      sel_p1 <= sel;
    end
  end

  assign out_q = out_p1;
  assign sel_q = sel_p1;
endmodule

// File: tb/tb_mux_16to1.sv
// Self-checking bench for mux_16to1: directed scenarios plus randomized
// traffic on a 1-bit and an 8-bit instance against a behavioural model.
module tb_mux_16to1;
  logic         clk = 1'b0;
  logic         clk_en = 1'b0;
  logic         rst = 1'b0;
  logic [15:0]  in1 = '0;
  logic [3:0]   sel1 = '0;
  logic [127:0] in8 = '0;
  logic [3:0]   sel8 = '0;
  logic         out1, out_q1;
  logic [3:0]   sel_q1, sel_q8;
  logic [7:0]   out8, out_q8;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic       exp_q1 = 1'b0;
  logic [3:0] exp_sq1 = '0;
  logic [7:0] exp_q8 = '0;
  logic [3:0] exp_sq8 = '0;

  mux_16to1 #(.DATA_W(1)) dut1 (
    .clk(clk), .rst(rst), .in(in1), .sel(sel1),
    .out(out1), .out_q(out_q1), .sel_q(sel_q1)
  );

  mux_16to1 #(.DATA_W(8)) dut8 (
    .clk(clk), .rst(rst), .in(in8), .sel(sel8),
    .out(out8), .out_q(out_q8), .sel_q(sel_q8)
  );

  initial forever begin
    #5;
    if (clk_en) clk = ~clk;
  end

  function automatic logic pick1(input logic [15:0] v, input logic [3:0] s);
    return v[s];
  endfunction

  function automatic logic [7:0] pick8(input logic [127:0] v, input logic [3:0] s);
    logic [127:0] t;
    t = v >> (8 * int'(s));
    return t[7:0];
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference for the registered path: value sampled at each rising edge.
  always @(posedge clk) begin
    if (rst) begin
      exp_q1 <= 1'b0; exp_sq1 <= '0; exp_q8 <= '0; exp_sq8 <= '0;
    end else begin
      exp_q1 <= pick1(in1, sel1); exp_sq1 <= sel1;
      exp_q8 <= pick8(in8, sel8); exp_sq8 <= sel8;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_out1",   {7'b0, out1},   {7'b0, pick1(in1, sel1)});
      check("cmp_outq1",  {7'b0, out_q1}, {7'b0, exp_q1});
      check("cmp_selq1",  {4'b0, sel_q1}, {4'b0, exp_sq1});
      check("cmp_out8",   out8,           pick8(in8, sel8));
      check("cmp_outq8",  out_q8,         exp_q8);
      check("cmp_selq8",  {4'b0, sel_q8}, {4'b0, exp_sq8});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] steps [4];
    logic       want  [4];
    steps = '{4'h0, 4'h1, 4'h6, 4'hC};
    want  = '{1'b0, 1'b1, 1'b0, 1'b1};

    // Scenario 1: purely combinational, clock stopped
    in1 = 16'h3F0A;
    for (int i = 0; i < 4; i++) begin
      sel1 = steps[i];
      #5;
      check($sformatf("s1_sel%0h", steps[i]), {7'b0, out1}, {7'b0, want[i]});
    end

    // Scenario 2: walking one
    for (int k = 0; k < 16; k++) begin
      for (int s = 0; s < 16; s++) begin
        in1 = 16'h0001 << k;
        sel1 = 4'(s);
        #1;
        check($sformatf("s2_k%0d_s%0d", k, s), {7'b0, out1}, (s == k) ? 8'h01 : 8'h00);
      end
    end

    // Scenario 5: 8-bit lanes
    in8 = 128'hA5 << 120;
    sel8 = 4'hF;
    #1 check("s5_selF", out8, 8'hA5);
    sel8 = 4'hE;
    #1 check("s5_selE", out8, 8'h00);

    // Start clock and reset
    rst = 1'b1;
    in1 = '0; sel1 = '0;
    clk_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_outq1", {7'b0, out_q1}, 8'h00);
    check("rst_selq1", {4'b0, sel_q1}, 8'h00);
    check("rst_outq8", out_q8, 8'h00);
    #1 rst = 1'b0;
    chk_en = 1'b1;

    // Scenario 3
    in1 = 16'h8000; sel1 = 4'hF;
    #1 check("s3_out_now", {7'b0, out1}, 8'h01);
    @(negedge clk);
    check("s3_outq", {7'b0, out_q1}, 8'h01);
    check("s3_selq", {4'b0, sel_q1}, 8'h0F);

    // Scenario 4: reset priority and combinational path during reset
    #1;
    in1 = 16'hFFFF; sel1 = 4'h3; rst = 1'b1;
    for (int e = 0; e < 2; e++) begin
      @(negedge clk);
      check($sformatf("s4_rst_outq_%0d", e), {7'b0, out_q1}, 8'h00);
      check($sformatf("s4_rst_selq_%0d", e), {4'b0, sel_q1}, 8'h00);
      check($sformatf("s4_rst_out_%0d", e),  {7'b0, out1},   8'h01);
    end
    #1 rst = 1'b0;
    @(negedge clk);
    check("s4_resume_outq", {7'b0, out_q1}, 8'h01);
    check("s4_resume_selq", {4'b0, sel_q1}, 8'h03);

    // Scenario 6: random traffic, occasional reset
    for (int c = 0; c < 1000; c++) begin
      #1;
      in1  = 16'($urandom);
      sel1 = 4'($urandom_range(0, 15));
      in8  = {$urandom, $urandom, $urandom, $urandom};
      sel8 = 4'($urandom_range(0, 15));
      rst  = ($urandom_range(0, 49) == 0);
      @(negedge clk);
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mux_16to1.md
MUX_16TO1 -- requirements
Module: mux_16to1

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 Parameter DATA_W, default 1: width in bits of each of the 16 data inputs.
REQ-003 Port clk, input, 1: rising-edge clock for the registered path.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port in, input, 16*DATA_W: input k occupies bits [k*DATA_W +: DATA_W], k = 0..15.
REQ-006 Port sel, input, 4: index of the selected input.
REQ-007 Port out, output, DATA_W: combinational selected data.
REQ-008 Port out_q, output, DATA_W: registered copy of out.
REQ-009 Port sel_q, output, 4: registered copy of sel, aligned with out_q.

Function
REQ-010 out SHALL equal input[sel] combinationally, with zero-cycle latency, independent of clk and rst.
REQ-011 out SHALL update within the same delta cycle as any change on in or sel; no clock is needed for out to be valid.
REQ-012 On each rising clk edge with rst low, out_q SHALL load input[sel] and sel_q SHALL load sel, giving one cycle of latency.
REQ-013 All 16 sel values SHALL be legal; sel = 4'hF SHALL select bits [15*DATA_W +: DATA_W], with no wrap or default case.
REQ-014 With DATA_W = 1 and in = 16'h3F0A, out SHALL be 0, 1, 0, 1 for sel = 0, 1, 6, C respectively.
REQ-015 If in or sel changes between clock edges, out_q SHALL reflect only the value sampled at the next rising edge.
REQ-016 out SHALL never be X or Z when in and sel are fully driven.

Reset
REQ-017 When rst is high at a rising clk edge, out_q SHALL become all zeros and sel_q SHALL become 4'h0.
REQ-018 Reset SHALL take priority over data capture in the same cycle.
REQ-019 Reset SHALL NOT affect out, which remains combinational during reset.
REQ-020 Registered capture SHALL resume on the first rising edge after rst goes low.

Structure
REQ-021 A shared package mux_16to1_pkg SHALL define the constants N_IN = 16 and SEL_W = 4 and the typedef sel_t as logic [SEL_W-1:0].
REQ-022 Selection SHALL be built from one sub-module, mux_2to1, parameterized by DATA_W.
REQ-023 The tree SHALL use 15 mux_2to1 instances in 4 levels, with sel[0] at the leaf level and sel[3] at the root.
REQ-024 The output registers SHALL reside in the top module only.

Verification
REQ-025 Scenario 1: DATA_W = 1, in = 16'h3F0A, sel stepped 0, 1, 6, C at 5 ns intervals with no clock -> out = 0, 1, 0, 1.
REQ-026 Scenario 2: walking-one on in (16'h0001 << k), sel = k for k = 0..15 -> out = 1; any sel != k -> out = 0.
REQ-027 Scenario 3: in = 16'h8000, sel = F, one rising clk edge -> out = 1 immediately and out_q = 1, sel_q = F after the edge.
REQ-028 Scenario 4: rst high for 2 edges while in = 16'hFFFF, sel = 3 -> out_q = 0, sel_q = 0, and out = 1 throughout; rst low -> out_q = 1 after the next edge.
REQ-029 Scenario 5: DATA_W = 8, in[127:120] = 8'hA5, other inputs 0, sel = F -> out = 8'hA5; sel = E -> out = 8'h00.
REQ-030 Scenario 6: random in and sel for 1000 cycles -> out matches the reference model every cycle, and out_q matches the previous cycle's model value.
